// File: rtl/bcd_pkg.sv
// Shared types and constants for the shared binary-to-BCD converter.
package bcd_pkg;

  localparam int unsigned NIBBLE_W    = 4;
  localparam int unsigned ADD3_THRESH = 5;
  localparam int unsigned ADD3_VAL    = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

  // Smallest digit count whose decimal range covers every bin_w-bit value.
  function automatic int unsigned min_digits(input int unsigned bin_w);
    longint unsigned max_val;
    longint unsigned lim;
    int unsigned     d;
    max_val = (64'd1 << bin_w) - 64'd1;
    lim     = 64'd1;
    d       = 0;
    while (lim <= max_val) begin
      lim = lim * 64'd10;
      d   = d + 1;
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble step: add 3 to every BCD nibble >= 5, then shift left by one.
module bcd_dabble_step
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic [DIGITS*NIBBLE_W+BIN_W-1:0] sr_i,
  output logic [DIGITS*NIBBLE_W+BIN_W-1:0] sr_o
);

  localparam int unsigned SR_W = DIGITS * NIBBLE_W + BIN_W;

  logic [SR_W-1:0]     adj;
  logic [NIBBLE_W-1:0] nib;

  // Per-digit correction (nibble-local, no carry), followed by the shift.
  always_comb begin
    adj = sr_i;
    nib = '0;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      nib = sr_i[BIN_W + d*NIBBLE_W +: NIBBLE_W];
      if (nib >= NIBBLE_W'(ADD3_THRESH)) begin
        adj[BIN_W + d*NIBBLE_W +: NIBBLE_W] = nib + NIBBLE_W'(ADD3_VAL);
      end
    end
    sr_o = adj << 1;
  end

endmodule

// File: rtl/bcd_conv_sched.sv
// Round-robin scheduler sharing one iterative double-dabble engine among NREQ requesters.
module bcd_conv_sched
  import bcd_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned BIN_W  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [NREQ*BIN_W-1:0]       req_data,
  output logic [NREQ-1:0]             req_ready,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [DIGITS*NIBBLE_W-1:0]  rsp_bcd,
  output logic [$clog2(NREQ)-1:0]     rsp_id,
  output logic                        busy
);

  localparam int unsigned ID_W  = $clog2(NREQ);
  localparam int unsigned BCD_W = DIGITS * NIBBLE_W;
  localparam int unsigned SR_W  = BCD_W + BIN_W;
  localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  if (DIGITS < min_digits(BIN_W)) begin : g_digits_chk
    $error("bcd_conv_sched: DIGITS too small to hold every BIN_W-bit value");
  end
  if (NREQ < 2 || NREQ > 8) begin : g_nreq_chk
    $error("bcd_conv_sched: NREQ must be in 2..8");
  end

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [BCD_W-1:0]  rsp_bcd_q, rsp_bcd_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic              busy_q, busy_d;

  logic [SR_W-1:0]   step_out;
  logic [NREQ-1:0]   grant_c;
  logic [ID_W-1:0]   gidx_c;
  logic [BIN_W-1:0]  gdata_c;
  logic              found;
  logic [ID_W-1:0]   idx;

  bcd_dabble_step #(
    .BIN_W  (BIN_W),
    .DIGITS (DIGITS)
  ) u_step (
    .sr_i (sr_q),
    .sr_o (step_out)
  );

  // Rotating-priority pick: first valid requester at or above rr_ptr, with wrap.
  always_comb begin
    grant_c = '0;
    gidx_c  = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = ID_W'((32'(rr_ptr_q) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found       = 1'b1;
        grant_c[idx] = 1'b1;
        gidx_c      = idx;
      end
    end
  end

  // Data word of the granted requester (grant is one-hot or zero).
  always_comb begin
    gdata_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_c[i]) gdata_c = req_data[i*BIN_W +: BIN_W];
    end
  end

  assign req_ready = (state_q == S_IDLE && !rst) ? grant_c : '0;

  // Next-state and datapath updates for IDLE -> SHIFT -> DONE.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_bcd_d   = rsp_bcd_q;
    rsp_id_d    = rsp_id_q;
    case (state_q)
      S_IDLE: begin
        if (|(req_valid & req_ready)) begin
          sr_d     = {{BCD_W{1'b0}}, gdata_c};
          rsp_id_d = gidx_c;
          rr_ptr_d = (32'(gidx_c) == NREQ - 1) ? '0 : gidx_c + ID_W'(1);
          cnt_d    = '0;
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sr_d  = step_out;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          rsp_bcd_d   = step_out[SR_W-1 -: BCD_W];
          rsp_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset abandons any conversion in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      sr_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_bcd_q   <= '0;
      rsp_id_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_bcd_q   <= rsp_bcd_d;
      rsp_id_q    <= rsp_id_d;
      busy_q      <= busy_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_bcd   = rsp_bcd_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Self-checking bench for bcd_conv_sched: scoreboard of decimal-model results plus per-cycle handshake model.
module tb_bcd_conv_sched;

  localparam int unsigned NREQ   = 4;
  localparam int unsigned BIN_W  = 16;
  localparam int unsigned DIGITS = 5;
  localparam int unsigned ID_W   = 2;
  localparam int unsigned BCD_W  = 20;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*BIN_W-1:0]  req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [BCD_W-1:0]       rsp_bcd;
  logic [ID_W-1:0]        rsp_id;
  logic                   busy;

  always #5 clk = ~clk;

  bcd_conv_sched #(
    .NREQ   (NREQ),
    .BIN_W  (BIN_W),
    .DIGITS (DIGITS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_bcd   (rsp_bcd),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  typedef struct {
    logic [ID_W-1:0]  id;
    logic [BCD_W-1:0] bcd;
  } exp_t;

  exp_t            sb[$];
  int              grant_log[$];
  int              errors = 0;
  int              checks = 0;
  int              cyc = 0;
  int              acc_edge = 0;
  int              n_acc = 0;
  logic            tb_idle = 1'b1;
  logic [ID_W-1:0] tb_ptr = '0;
  logic            armed = 1'b0;
  logic [NREQ-1:0] acc_vec = '0;

  function automatic logic [BCD_W-1:0] to_bcd(input logic [BIN_W-1:0] v);
    int unsigned      x;
    logic [BCD_W-1:0] r;
    x = 32'(v);
    r = '0;
    for (int d = 0; d < DIGITS; d++) begin
      r[d*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [NREQ-1:0] arb(input logic [NREQ-1:0] v, input logic [ID_W-1:0] p);
    logic [NREQ-1:0] g;
    int unsigned     j;
    g = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = (32'(p) + 32'(k)) % NREQ;
      if (v[j]) begin
        g[j] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs against the model, track handshakes, advance the model.
  task automatic cycle();
    logic [NREQ-1:0]  exp_rdy;
    logic             exp_rv;
    logic             hs;
    int               g;
    logic [BIN_W-1:0] gd;
    exp_t             e;
    #1;
    exp_rdy = (rst || !tb_idle) ? '0 : arb(req_valid, tb_ptr);
    exp_rv  = !tb_idle && ((cyc - acc_edge) >= int'(BIN_W));
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    if (armed) begin
      check("busy", 64'(busy), 64'(!tb_idle));
      check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    end
    hs = (rsp_valid === 1'b1) && rsp_ready && !rst;
    g  = -1;
    gd = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && req_ready[i] === 1'b1) begin
        g  = i;
        gd = req_data[i*BIN_W +: BIN_W];
      end
    end
    if (hs) begin
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("rsp_bcd", 64'(rsp_bcd), 64'(e.bcd));
        check("rsp_id", 64'(rsp_id), 64'(e.id));
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    acc_vec = '0;
    if (rst) begin
      tb_idle = 1'b1;
      tb_ptr  = '0;
      sb.delete();
      armed   = 1'b1;
    end else begin
      if (hs) tb_idle = 1'b1;
      if (g >= 0) begin
        sb.push_back('{id: ID_W'(g), bcd: to_bcd(gd)});
        tb_idle    = 1'b0;
        tb_ptr     = ID_W'((g + 1) % NREQ);
        acc_edge   = cyc;
        n_acc++;
        grant_log.push_back(g);
        acc_vec[g] = 1'b1;
      end
    end
  endtask

  task automatic send(input int i, input logic [BIN_W-1:0] d);
    int n;
    n = 0;
    req_data[i*BIN_W +: BIN_W] = d;
    req_valid[i] = 1'b1;
    do begin
      cycle();
      n++;
    end while (!acc_vec[i] && n < 100);
    check("accept_timeout", 64'(acc_vec[i]), 64'd1);
    req_valid[i] = 1'b0;
    req_data[i*BIN_W +: BIN_W] = ~d;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rsp_ready = 1'b1;
    while ((!tb_idle || sb.size() != 0) && n < 200) begin
      cycle();
      n++;
    end
    check("drain_timeout", 64'(tb_idle && sb.size() == 0), 64'd1);
  endtask

  task automatic accept_all(input int count);
    int base;
    int n;
    base = grant_log.size();
    n = 0;
    while (grant_log.size() < base + count && n < 400) begin
      cycle();
      n++;
      for (int i = 0; i < NREQ; i++) if (acc_vec[i]) req_valid[i] = 1'b0;
    end
    check("accept_all_timeout", 64'(grant_log.size() >= base + count), 64'd1);
  endtask

  initial begin
    logic [BCD_W-1:0] hold_bcd;
    logic [ID_W-1:0]  hold_id;
    int               n;
    int               base;

    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
    repeat (2) cycle();
    rst = 1'b0;
    check("rst_bcd", 64'(rsp_bcd), 64'd0);
    check("rst_id", 64'(rsp_id), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);

    // Single request and boundary values.
    rsp_ready = 1'b1;
    send(0, 16'd12345);
    drain();
    send(1, 16'd0);
    drain();
    send(2, 16'd65535);
    drain();
    send(3, 16'd9);
    drain();
    send(0, 16'd10);
    drain();

    // Round-robin with all requesters continuously valid, from a fresh pointer.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    grant_log.delete();
    for (int i = 0; i < NREQ; i++) req_data[i*BIN_W +: BIN_W] = BIN_W'($urandom);
    req_valid = '1;
    n = 0;
    while (grant_log.size() < 8 && n < 400) begin
      cycle();
      n++;
      for (int i = 0; i < NREQ; i++) if (acc_vec[i]) req_data[i*BIN_W +: BIN_W] = BIN_W'($urandom);
    end
    req_valid = '0;
    drain();
    check("rr_count", 64'(grant_log.size() >= 8), 64'd1);
    for (int k = 0; k < 8 && k < grant_log.size(); k++) check("rr_grant", 64'(grant_log[k]), 64'(k % NREQ));

    // Backpressure: hold the result for 10 cycles while others wait.
    rsp_ready = 1'b0;
    send(2, 16'd4321);
    req_data[0*BIN_W +: BIN_W] = 16'd100;
    req_data[1*BIN_W +: BIN_W] = 16'd59999;
    req_valid[1:0] = 2'b11;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin
      cycle();
      n++;
    end
    check("bp_valid", 64'(rsp_valid), 64'd1);
    check("bp_bcd", 64'(rsp_bcd), 64'(to_bcd(16'd4321)));
    hold_bcd = rsp_bcd;
    hold_id  = rsp_id;
    repeat (10) begin
      cycle();
      check("bp_hold_bcd", 64'(rsp_bcd), 64'(hold_bcd));
      check("bp_hold_id", 64'(rsp_id), 64'(hold_id));
      check("bp_req_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    base = sb.size();
    cycle();
    check("bp_release_valid", 64'(rsp_valid), 64'd0);
    check("bp_single_pop", 64'(sb.size()), 64'(base - 1));
    accept_all(2);
    drain();

    // Reset during SHIFT: the aborted word must never come back.
    send(2, 16'd777);
    repeat (5) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    for (int i = 0; i < NREQ; i++) req_data[i*BIN_W +: BIN_W] = BIN_W'(i * 1111);
    req_valid = '1;
    #1;
    check("abort_ptr", 64'(req_ready), 64'b0001);
    accept_all(4);
    drain();
    repeat (40) cycle();

    // Random mixed traffic against the decimal model.
    base = n_acc;
    n = 0;
    while (n_acc < base + 1500 && n < 60000) begin
      for (int i = 0; i < NREQ; i++) begin
        if (acc_vec[i]) begin
          req_valid[i] = ($urandom_range(0, 2) == 0);
          req_data[i*BIN_W +: BIN_W] = BIN_W'($urandom);
        end else if (!req_valid[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            req_valid[i] = 1'b1;
            req_data[i*BIN_W +: BIN_W] = BIN_W'($urandom);
          end
        end else if ($urandom_range(0, 49) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
      n++;
    end
    check("random_count", 64'(n_acc >= base + 1500), 64'd1);
    req_valid = '0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
